hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS core. Watches the decode-stage

---
 rtl/hazard_ctrl.sv | 92 +++++++++
 tb/tb_hazard_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch/jump squash and EX forwarding control for a 5-stage MIPS pipe.
module hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic [RA_W-1:0]  id_write_reg,
  input  logic             id_mem_read,
  input  logic             id_jump,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [1:0] REM_INIT = 2'(LOAD_STALL - 1);
  state_t           r_state;
  logic [1:0]       r_rem;
  logic             r_ex_v, r_ex_rw, r_ex_mr, r_mem_v, r_wb_v;
  logic [RA_W-1:0]  r_ex_rs, r_ex_rt, r_ex_dest, r_mem_dest, r_wb_dest;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_load_use, w_stall;
  assign w_load_use = id_valid & r_ex_v & r_ex_mr & r_ex_rw & (r_ex_dest != '0) &
                      ((r_ex_dest == id_rs) | (id_uses_rt & (r_ex_dest == id_rt)));
  assign w_stall    = !ex_branch_taken & ((r_state == STALL) | w_load_use);
  assign pc_write   = !w_stall;
  assign ifid_write = !w_stall;
  assign idex_flush = ex_branch_taken | w_stall;
  assign ifid_flush = ex_branch_taken | (id_jump & id_valid & !w_stall);
  // mem/wb valid bits already fold in RegWrite and dest != $0
  assign fwd_a = !r_ex_v ? 2'b00 : (r_mem_v && r_mem_dest == r_ex_rs) ? 2'b10 :
                 (r_wb_v && r_wb_dest == r_ex_rs) ? 2'b01 : 2'b00;
  assign fwd_b = !r_ex_v ? 2'b00 : (r_mem_v && r_mem_dest == r_ex_rt) ? 2'b10 :
                 (r_wb_v && r_wb_dest == r_ex_rt) ? 2'b01 : 2'b00;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_rem       <= '0;
      r_ex_v      <= 1'b0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_dest   <= '0;
      r_mem_v     <= 1'b0;
      r_mem_dest  <= '0;
      r_wb_v      <= 1'b0;
      r_wb_dest   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_ex_v     <= id_valid & !idex_flush;
      r_ex_rw    <= id_reg_write;
      r_ex_mr    <= id_mem_read;
      r_ex_rs    <= id_rs;
      r_ex_rt    <= id_rt;
      r_ex_dest  <= id_write_reg;
      r_mem_v    <= r_ex_v & r_ex_rw & (r_ex_dest != '0);
      r_mem_dest <= r_ex_dest;
      r_wb_v     <= r_mem_v;
      r_wb_dest  <= r_mem_dest;
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (ifid_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (ex_branch_taken) begin
        r_state <= RUN;
        r_rem   <= '0;
      end else if (r_state == RUN) begin
        if (w_load_use && LOAD_STALL > 1) begin
          r_state <= STALL;
          r_rem   <= REM_INIT;
        end
      end else begin
        r_rem <= r_rem - 2'd1;
        if (r_rem == 2'd1) r_state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of a default instance and a LOAD_STALL=2, CNT_W=2 instance.
module tb_hazard_ctrl;
  logic       clk = 0, rst = 1;
  logic       id_valid, id_uses_rt, id_reg_write, id_mem_read, id_jump, ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_write_reg;
  logic       a_pcw, a_ifidw, a_ifidf, a_idexf, b_pcw, b_ifidw, b_ifidf, b_idexf;
  logic [1:0] a_fa, a_fb, b_fa, b_fb, b_stall, b_flush;
  logic [15:0] a_stall, a_flush;
  int n_pass = 0, n_chk = 0;
  always #5 clk = ~clk;
  hazard_ctrl u_a (.clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_write_reg(id_write_reg),
    .id_mem_read(id_mem_read), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .pc_write(a_pcw), .ifid_write(a_ifidw), .ifid_flush(a_ifidf), .idex_flush(a_idexf),
    .fwd_a(a_fa), .fwd_b(a_fb), .stall_cnt(a_stall), .flush_cnt(a_flush));
  hazard_ctrl #(.LOAD_STALL(2), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_write_reg(id_write_reg), .id_mem_read(id_mem_read), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken), .pc_write(b_pcw), .ifid_write(b_ifidw),
    .ifid_flush(b_ifidf), .idex_flush(b_idexf), .fwd_a(b_fa), .fwd_b(b_fb),
    .stall_cnt(b_stall), .flush_cnt(b_flush));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic id(input logic v, input int rs, input int rt, input logic urt, input logic rw,
                    input int wr, input logic mr, input logic j);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt; id_reg_write = rw;
    id_write_reg = 5'(wr); id_mem_read = mr; id_jump = j; ex_branch_taken = 0;
  endtask
  task automatic idle; id(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tick; @(posedge clk); #1; endtask
  task automatic do_reset; idle; rst = 1; #1; tick; rst = 0; endtask
  task automatic lw7;  id(1, 1, 7, 0, 1, 7, 1, 0); endtask
  task automatic add8; id(1, 7, 2, 1, 1, 8, 0, 0); endtask
  initial begin
    idle; #1;
    check("rst_pcw", a_pcw, 1); check("rst_ifidw", a_ifidw, 1); check("rst_ifidf", a_ifidf, 0);
    check("rst_idexf", a_idexf, 0); check("rst_fwd", {a_fa, a_fb}, 0); check("rst_cnt", a_stall, 0);
    do_reset;
    // single-bubble load-use
    lw7; #1; check("t1_lw_pcw", a_pcw, 1); tick;
    add8; #1; check("t1_pcw", a_pcw, 0); check("t1_idexf", a_idexf, 1); check("t1_ifidw", a_ifidw, 0); tick;
    #1; check("t1_release_pcw", a_pcw, 1); check("t1_release_idexf", a_idexf, 0);
    check("t1_stall_cnt", a_stall, 1); tick;
    idle; #1; check("t1_fwd_a", a_fa, 2'b01); check("t1_fwd_b", a_fb, 2'b00);
    // two-bubble load-use
    do_reset;
    lw7; tick;
    add8; #1; check("t2_pcw0", b_pcw, 0); tick;
    #1; check("t2_pcw1", b_pcw, 0); check("t2_idexf1", b_idexf, 1); check("t2_cnt1", b_stall, 1); tick;
    #1; check("t2_run_pcw", b_pcw, 1); check("t2_run_idexf", b_idexf, 0); check("t2_cnt2", b_stall, 2); tick;
    idle; #1; check("t2_fwd_a", b_fa, 0);
    // branch taken in the second stall cycle
    do_reset;
    lw7; tick;
    add8; #1; check("t3_stall", b_pcw, 0); tick;
    add8; ex_branch_taken = 1; #1;
    check("t3_pcw", b_pcw, 1); check("t3_ifidf", b_ifidf, 1); check("t3_idexf", b_idexf, 1);
    check("t3_ifidw", b_ifidw, 1); tick;
    idle; #1; check("t3_run_idexf", b_idexf, 0); check("t3_run_pcw", b_pcw, 1);
    check("t3_flush_cnt", b_flush, 1); check("t3_stall_cnt", b_stall, 1);
    // forwarding: back-to-back, one gap, MEM over WB, $0
    do_reset;
    id(1, 1, 2, 1, 1, 3, 0, 0); tick; id(1, 3, 3, 1, 1, 4, 0, 0); tick;
    idle; #1; check("t4_mem_fwd", {a_fa, a_fb}, 4'b1010);
    do_reset;
    id(1, 1, 2, 1, 1, 3, 0, 0); tick; id(1, 1, 1, 1, 1, 5, 0, 0); tick; id(1, 3, 3, 1, 1, 4, 0, 0); tick;
    idle; #1; check("t4_wb_fwd", {a_fa, a_fb}, 4'b0101);
    do_reset;
    id(1, 1, 2, 1, 1, 3, 0, 0); tick; id(1, 6, 6, 1, 1, 3, 0, 0); tick; id(1, 3, 3, 1, 1, 4, 0, 0); tick;
    idle; #1; check("t4_mem_beats_wb", {a_fa, a_fb}, 4'b1010);
    do_reset;
    id(1, 1, 2, 1, 1, 0, 0, 0); tick; id(1, 0, 0, 1, 1, 4, 0, 0); tick;
    idle; #1; check("t4_reg0", {a_fa, a_fb}, 4'b0000);
    // jump squash and counter saturation
    do_reset;
    id(1, 0, 0, 0, 0, 0, 0, 1); #1;
    check("t5_ifidf", a_ifidf, 1); check("t5_pcw", a_pcw, 1); check("t5_idexf", a_idexf, 0); tick;
    idle; #1; check("t5_ifidf_off", a_ifidf, 0); check("t5_flush_cnt", a_flush, 1);
    do_reset;
    id(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) tick;
    #1; check("t5_flush_sat", b_flush, 3);
    // asynchronous reset mid-stall
    do_reset;
    lw7; tick; add8; tick;
    #1; check("t6_in_stall", b_pcw, 0);
    rst = 1; #1;
    check("t6_pcw", b_pcw, 1); check("t6_idexf", b_idexf, 0); check("t6_ifidw", b_ifidw, 1);
    check("t6_stall_cnt", b_stall, 0); check("t6_flush_cnt", b_flush, 0);
    idle; tick; rst = 0;
    add8; #1; check("t6_post_pcw", b_pcw, 1); tick;
    idle; #1; check("t6_no_stale_fwd", b_fa, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
